// File: rtl/branch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : branch_pkg
//  Description : Shared definitions for the branch resolver: data width,
//                branch-type encodings, FSM state encoding and the branch
//                condition helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package branch_pkg;

  localparam int unsigned XLEN = 32;

  // Branch/jump op encodings as presented on br_type.
  typedef enum logic [1:0] {
    BR_BEQ  = 2'b00,
    BR_BNE  = 2'b01,
    BR_J    = 2'b10,
    BR_RSVD = 2'b11
  } br_type_e;

  // Resolver FSM states.
  typedef enum logic [1:0] {
    ST_RUN       = 2'b00,
    ST_WAIT_FLAG = 2'b01,
    ST_REDIRECT  = 2'b10
  } state_e;

  // Conditional-branch outcome from the captured type and the ALU zero flag.
  function automatic logic branch_taken(input br_type_e t, input logic z);
    return ((t == BR_BEQ) && z) || ((t == BR_BNE) && !z);
  endfunction

endpackage : branch_pkg
`default_nettype wire

// File: rtl/branch_target_adder.sv
`default_nettype none
// ============================================================================
//  Module      : branch_target_adder
//  Description : Conditional-branch target generator:
//                target = base + (sign-extended offset << 2), modulo 2^32.
//  Ports       : base   - word-aligned base address (pc+4 of the branch)
//                offset - signed 16-bit word offset
//                target - resulting branch target
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_target_adder
  import branch_pkg::*;
(
  input  logic [XLEN-1:0] base,
  input  logic [15:0]     offset,
  output logic [XLEN-1:0] target
);

  logic [XLEN-1:0] offset_bytes;

  // Word offset becomes a byte offset: sign-extend, then shift left by two.
  assign offset_bytes = {{(XLEN-18){offset[15]}}, offset, 2'b00};
  assign target       = base + offset_bytes;

endmodule : branch_target_adder
`default_nettype wire

// File: rtl/branch_resolver.sv
`default_nettype none
// ============================================================================
//  Module      : branch_resolver
//  Description : Fetch-PC sequencer that accepts branch/jump ops, waits for
//                the ALU zero flag on conditional branches, and redirects
//                the PC with a one-cycle flush pulse when a branch is taken.
//  Ports       : clk, rst_n     - clock, asynchronous active-low reset
//                stall          - hold the PC while in RUN
//                br_valid/ready - branch op handshake (ready only in RUN)
//                br_type        - 00 BEQ, 01 BNE, 10 J, 11 no-op
//                br_offset      - signed word offset for BEQ/BNE
//                br_index       - J target word index
//                zero_valid     - ALU zero flag valid this cycle
//                zero           - ALU zero flag
//                pc             - current fetch PC
//                flush          - one-cycle pulse when the PC is redirected
//                timeout_err    - sticky, flag never arrived for a branch
//                taken_cnt      - saturating count of taken branches/jumps
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_resolver
  import branch_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLAG_TIMEOUT = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            br_valid,
  output logic            br_ready,
  input  logic [1:0]      br_type,
  input  logic [15:0]     br_offset,
  input  logic [25:0]     br_index,
  input  logic            zero_valid,
  input  logic            zero,
  output logic [XLEN-1:0] pc,
  output logic            flush,
  output logic            timeout_err,
  output logic [15:0]     taken_cnt
);

  // The wait counter runs 0..FLAG_TIMEOUT-1, so WAIT_FLAG lasts at most
  // FLAG_TIMEOUT cycles; the abort fires on the last of them.
  localparam logic [7:0] TIMEOUT_LAST = 8'(FLAG_TIMEOUT - 1);

  state_e          state;
  br_type_e        type_q;
  logic [XLEN-1:0] base_q;
  logic [15:0]     offset_q;
  logic [XLEN-1:0] target_q;
  logic [7:0]      wait_cnt;

  logic [XLEN-1:0] pc_inc;
  logic [XLEN-1:0] j_target;
  logic [XLEN-1:0] br_target;
  logic            handshake;
  br_type_e        in_type;

  assign br_ready  = (state == ST_RUN);
  assign handshake = br_valid && br_ready;
  assign in_type   = br_type_e'(br_type);

  // Sequential incrementer; natural 32-bit overflow gives FFFF_FFFC -> 0.
  assign pc_inc    = pc + 32'd4;

  // Jump target keeps the 256 MB region of the delay-slot address (pc+4).
  assign j_target  = {pc_inc[31:28], br_index, 2'b00};

  branch_target_adder u_target_adder (
    .base   (base_q),
    .offset (offset_q),
    .target (br_target)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_RUN;
      pc          <= RESET_PC;
      flush       <= 1'b0;
      timeout_err <= 1'b0;
      taken_cnt   <= 16'd0;
      type_q      <= BR_BEQ;
      base_q      <= '0;
      offset_q    <= 16'd0;
      target_q    <= '0;
      wait_cnt    <= 8'd0;
    end else begin
      flush <= 1'b0;
      case (state)
        ST_RUN: begin
          // An accepted op overrides stall in the same cycle.
          if (handshake) begin
            case (in_type)
              BR_BEQ, BR_BNE: begin
                base_q   <= pc_inc;
                type_q   <= in_type;
                offset_q <= br_offset;
                pc       <= pc_inc;
                wait_cnt <= 8'd0;
                state    <= ST_WAIT_FLAG;
              end
              BR_J: begin
                target_q <= j_target;
                pc       <= pc_inc;
                state    <= ST_REDIRECT;
              end
              default: begin
                // Reserved encoding behaves as a plain sequential step.
                pc <= pc_inc;
              end
            endcase
          end else if (!stall) begin
            pc <= pc_inc;
          end
        end

        ST_WAIT_FLAG: begin
          // The flag is checked before the timeout so a flag arriving in
          // the final wait cycle still resolves the branch normally.
          if (zero_valid) begin
            if (branch_taken(type_q, zero)) begin
              target_q <= br_target;
              state    <= ST_REDIRECT;
            end else begin
              state <= ST_RUN;
            end
          end else if (wait_cnt == TIMEOUT_LAST) begin
            timeout_err <= 1'b1;
            state       <= ST_RUN;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        ST_REDIRECT: begin
          pc    <= target_q;
          flush <= 1'b1;
          if (taken_cnt != 16'hFFFF) begin
            taken_cnt <= taken_cnt + 16'd1;
          end
          state <= ST_RUN;
        end

        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

endmodule : branch_resolver
`default_nettype wire

// File: tb/tb_branch_resolver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_resolver
//  Description : Self-checking bench for branch_resolver: directed vector
//                table, hand-written timeout/reset sequences, and a random
//                run compared against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolver;

  localparam int FT = 8;
  localparam longint MASK32 = 64'h0000_0000_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        br_valid = 1'b0;
  logic [1:0]  br_type = 2'b00;
  logic [15:0] br_offset = 16'd0;
  logic [25:0] br_index = 26'd0;
  logic        zero_valid = 1'b0;
  logic        zero = 1'b0;
  logic        br_ready;
  logic [31:0] pc;
  logic        flush;
  logic        timeout_err;
  logic [15:0] taken_cnt;

  int total = 0;
  int bad = 0;

  branch_resolver #(
    .RESET_PC     (32'h0000_0000),
    .FLAG_TIMEOUT (FT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .br_valid    (br_valid),
    .br_ready    (br_ready),
    .br_type     (br_type),
    .br_offset   (br_offset),
    .br_index    (br_index),
    .zero_valid  (zero_valid),
    .zero        (zero),
    .pc          (pc),
    .flush       (flush),
    .timeout_err (timeout_err),
    .taken_cnt   (taken_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  longint m_pc;
  bit     m_flush;
  bit     m_timeout;
  int     m_taken;
  bit     m_waiting;
  bit     m_redirecting;
  int     m_wait_left;
  longint m_base;
  longint m_off;
  bit     m_is_bne;
  longint m_target;

  task automatic model_reset();
    m_pc = 0; m_flush = 0; m_timeout = 0; m_taken = 0;
    m_waiting = 0; m_redirecting = 0; m_wait_left = 0;
    m_base = 0; m_off = 0; m_is_bne = 0; m_target = 0;
  endtask

  function automatic bit model_ready();
    return !m_waiting && !m_redirecting;
  endfunction

  // Advance the model by one rising edge using the current inputs.
  task automatic model_edge();
    longint nxt;
    bit     tk;
    m_flush = 0;
    if (m_redirecting) begin
      m_pc = m_target;
      m_flush = 1;
      if (m_taken < 65535) m_taken++;
      m_redirecting = 0;
    end else if (m_waiting) begin
      if (zero_valid) begin
        tk = m_is_bne ? !zero : zero;
        if (tk) begin
          m_target = (m_base + m_off * 4) & MASK32;
          m_redirecting = 1;
        end
        m_waiting = 0;
      end else begin
        m_wait_left--;
        if (m_wait_left == 0) begin
          m_timeout = 1;
          m_waiting = 0;
        end
      end
    end else begin
      nxt = (m_pc + 4) & MASK32;
      if (br_valid) begin
        if (br_type == 2'd0 || br_type == 2'd1) begin
          m_base = nxt;
          m_is_bne = (br_type == 2'd1);
          m_off = longint'($signed(br_offset));
          m_waiting = 1;
          m_wait_left = FT;
        end else if (br_type == 2'd2) begin
          m_target = (nxt & 64'hF000_0000) | (longint'(br_index) * 4);
          m_redirecting = 1;
        end
        m_pc = nxt;
      end else if (!stall) begin
        m_pc = nxt;
      end
    end
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic v, input logic [1:0] ty,
                       input logic [15:0] off, input logic [25:0] idx,
                       input logic zv, input logic z);
    stall = st; br_valid = v; br_type = ty; br_offset = off;
    br_index = idx; zero_valid = zv; zero = z;
  endtask

  task automatic idle();
    drive(0, 0, 2'd0, 16'd0, 26'd0, 0, 0);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        st;
    logic        v;
    logic [1:0]  ty;
    logic [15:0] off;
    logic [25:0] idx;
    logic        zv;
    logic        z;
    logic        exp_ready;
    logic [31:0] exp_pc;
    logic        exp_flush;
    logic [15:0] exp_cnt;
  } vec_t;

  function automatic vec_t mkv(input logic st, input logic v, input logic [1:0] ty,
                               input logic [15:0] off, input logic [25:0] idx,
                               input logic zv, input logic z, input logic er,
                               input logic [31:0] epc, input logic ef,
                               input logic [15:0] ec);
    vec_t r;
    r.st = st; r.v = v; r.ty = ty; r.off = off; r.idx = idx; r.zv = zv; r.z = z;
    r.exp_ready = er; r.exp_pc = epc; r.exp_flush = ef; r.exp_cnt = ec;
    return r;
  endfunction

  vec_t vecs [0:25];

  initial begin
    //               st v  ty  off       idx          zv z  rdy pc            fl cnt
    vecs[0]  = mkv(0, 0, 2'd0, 16'h0000, 26'h0,       0, 0, 1, 32'h0000_0004, 0, 16'd0);
    vecs[1]  = mkv(0, 0, 2'd0, 16'h0000, 26'h0,       0, 0, 1, 32'h0000_0008, 0, 16'd0);
    vecs[2]  = mkv(0, 0, 2'd0, 16'h0000, 26'h0,       0, 0, 1, 32'h0000_000C, 0, 16'd0);
    vecs[3]  = mkv(1, 0, 2'd0, 16'h0000, 26'h0,       0, 0, 1, 32'h0000_000C, 0, 16'd0);
    vecs[4]  = mkv(1, 1, 2'd2, 16'h0000, 26'h40,      0, 0, 1, 32'h0000_0010, 0, 16'd0);
    vecs[5]  = mkv(0, 0, 2'd0, 16'h0000, 26'h0,       0, 0, 0, 32'h0000_0100, 1, 16'd1);
    vecs[6]  = mkv(0, 1, 2'd0, 16'h0004, 26'h0,       0, 0, 1, 32'h0000_0104, 0, 16'd1);
    vecs[7]  = mkv(0, 0, 2'd0, 16'h0000, 26'h0,       0, 0, 0, 32'h0000_0104, 0, 16'd1);
    vecs[8]  = mkv(1, 0, 2'd0, 16'h0000, 26'h0,       0, 0, 0, 32'h0000_0104, 0, 16'd1);
    vecs[9]  = mkv(0, 0, 2'd0, 16'h0000, 26'h0,       1, 1, 0, 32'h0000_0104, 0, 16'd1);
    vecs[10] = mkv(0, 0, 2'd0, 16'h0000, 26'h0,       0, 0, 0, 32'h0000_0114, 1, 16'd2);
    vecs[11] = mkv(0, 0, 2'd0, 16'h0000, 26'h0,       0, 0, 1, 32'h0000_0118, 0, 16'd2);
    vecs[12] = mkv(0, 1, 2'd1, 16'hFFFE, 26'h0,       0, 0, 1, 32'h0000_011C, 0, 16'd2);
    vecs[13] = mkv(0, 0, 2'd0, 16'h0000, 26'h0,       1, 1, 0, 32'h0000_011C, 0, 16'd2);
    vecs[14] = mkv(0, 0, 2'd0, 16'h0000, 26'h0,       0, 0, 1, 32'h0000_0120, 0, 16'd2);
    vecs[15] = mkv(0, 1, 2'd1, 16'hFFFE, 26'h0,       0, 0, 1, 32'h0000_0124, 0, 16'd2);
    vecs[16] = mkv(0, 0, 2'd0, 16'h0000, 26'h0,       1, 0, 0, 32'h0000_0124, 0, 16'd2);
    vecs[17] = mkv(0, 0, 2'd0, 16'h0000, 26'h0,       0, 0, 0, 32'h0000_011C, 1, 16'd3);
    vecs[18] = mkv(1, 1, 2'd3, 16'h0000, 26'h0,       0, 0, 1, 32'h0000_0120, 0, 16'd3);
    vecs[19] = mkv(0, 0, 2'd0, 16'h0000, 26'h0,       1, 1, 1, 32'h0000_0124, 0, 16'd3);
    vecs[20] = mkv(0, 1, 2'd0, 16'h8000, 26'h0,       0, 0, 1, 32'h0000_0128, 0, 16'd3);
    vecs[21] = mkv(0, 0, 2'd0, 16'h0000, 26'h0,       1, 1, 0, 32'h0000_0128, 0, 16'd3);
    vecs[22] = mkv(0, 0, 2'd0, 16'h0000, 26'h0,       0, 0, 0, 32'hFFFE_0128, 1, 16'd4);
    vecs[23] = mkv(0, 1, 2'd2, 16'h0000, 26'h3FF_FFFF, 0, 0, 1, 32'hFFFE_012C, 0, 16'd4);
    vecs[24] = mkv(0, 0, 2'd0, 16'h0000, 26'h0,       0, 0, 0, 32'hFFFF_FFFC, 1, 16'd5);
    vecs[25] = mkv(0, 0, 2'd0, 16'h0000, 26'h0,       0, 0, 1, 32'h0000_0000, 0, 16'd5);

    // ---- reset ----
    model_reset();
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pc", pc, 0);
    chk("reset_flush", flush, 0);
    chk("reset_timeout", timeout_err, 0);
    chk("reset_cnt", taken_cnt, 0);
    chk("reset_ready", br_ready, 1);
    rst_n = 1'b1;

    // ---- directed vector table ----
    for (int i = 0; i < 26; i++) begin
      drive(vecs[i].st, vecs[i].v, vecs[i].ty, vecs[i].off, vecs[i].idx,
            vecs[i].zv, vecs[i].z);
      chk($sformatf("vec%0d_ready", i), br_ready, vecs[i].exp_ready);
      tick();
      chk($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
      chk($sformatf("vec%0d_flush", i), flush, vecs[i].exp_flush);
      chk($sformatf("vec%0d_cnt", i), taken_cnt, vecs[i].exp_cnt);
    end
    chk("table_timeout", timeout_err, 0);

    // ---- flag arriving in the final wait cycle wins over the timeout ----
    drive(0, 1, 2'd0, 16'h0010, 26'd0, 0, 0);
    tick();
    chk("fw_pc_base", pc, 32'h4);
    idle();
    for (int i = 0; i < FT - 1; i++) begin
      chk("fw_wait_ready", br_ready, 0);
      tick();
      chk("fw_wait_pc", pc, 32'h4);
    end
    drive(0, 0, 2'd0, 16'd0, 26'd0, 1, 1);
    tick();
    chk("fw_redirect_ready", br_ready, 0);
    chk("fw_no_timeout", timeout_err, 0);
    idle();
    tick();
    chk("fw_target_pc", pc, 32'h44);
    chk("fw_flush", flush, 1);
    chk("fw_cnt", taken_cnt, 6);

    // ---- timeout: flag never arrives ----
    drive(0, 1, 2'd0, 16'h0001, 26'd0, 0, 0);
    tick();
    chk("to_pc_base", pc, 32'h48);
    idle();
    for (int i = 0; i < FT; i++) begin
      chk("to_wait_ready", br_ready, 0);
      tick();
      chk($sformatf("to_err_%0d", i), timeout_err, (i == FT - 1) ? 1 : 0);
      chk("to_wait_pc", pc, 32'h48);
    end
    chk("to_ready_after", br_ready, 1);
    tick();
    chk("to_pc_resume", pc, 32'h4C);
    chk("to_no_flush", flush, 0);
    chk("to_sticky", timeout_err, 1);
    chk("to_cnt", taken_cnt, 6);

    // ---- reset during WAIT_FLAG discards the branch ----
    drive(0, 1, 2'd0, 16'h0004, 26'd0, 0, 0);
    tick();
    idle();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("rw_pc", pc, 0);
    chk("rw_ready", br_ready, 1);
    chk("rw_timeout", timeout_err, 0);
    chk("rw_cnt", taken_cnt, 0);
    model_reset();
    #1 rst_n = 1'b1;
    drive(0, 0, 2'd0, 16'd0, 26'd0, 1, 1);
    tick();
    chk("rw_zv_ignored_pc", pc, 32'h4);
    chk("rw_zv_no_flush", flush, 0);
    idle();
    tick();
    chk("rw_pc2", pc, 32'h8);
    chk("rw_flush2", flush, 0);

    // ---- reset during REDIRECT: no flush after release ----
    drive(0, 1, 2'd2, 16'd0, 26'h100, 0, 0);
    tick();
    chk("rr_in_redirect", br_ready, 0);
    idle();
    #2 rst_n = 1'b0;
    #1;
    chk("rr_pc", pc, 0);
    chk("rr_ready", br_ready, 1);
    model_reset();
    #1 rst_n = 1'b1;
    tick();
    chk("rr_no_flush", flush, 0);
    chk("rr_pc_after", pc, 32'h4);
    chk("rr_cnt", taken_cnt, 0);

    // ---- randomized run against the model ----
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 35),
            2'($urandom_range(0, 3)), 16'($urandom), 26'($urandom),
            ($urandom_range(0, 99) < 25), 1'($urandom));
      chk("rnd_ready", br_ready, model_ready());
      tick();
      chk("rnd_pc", pc, m_pc);
      chk("rnd_flush", flush, m_flush);
      chk("rnd_timeout", timeout_err, m_timeout);
      chk("rnd_cnt", taken_cnt, m_taken);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_branch_resolver
`default_nettype wire
